// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display pipeline: 640x480@60 timing,
// RGB565 colour constants and the invalid-coordinate marker.
package vga_pkg;

  // 640x480@60 Hz timing, in pixel clocks (horizontal) and lines (vertical)
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_VALID_DEF = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;

  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_VALID_DEF = 480;
  localparam int V_FRONT_DEF = 10;
  localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;

  // Coordinate value driven whenever no pixel is being requested
  localparam logic [9:0] COORD_INVALID = 10'h3FF;

  typedef logic [15:0] rgb565_t;

  // RGB565 colours
  localparam rgb565_t WHITE   = 16'hFFFF;
  localparam rgb565_t BLACK   = 16'h0000;
  localparam rgb565_t GOLDEN  = 16'hFEC0;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t MAGENTA = 16'hF81F;
  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t BLUE    = 16'h001F;

  // Colour of test-pattern bar number idx, left to right
  function automatic rgb565_t bar_color(input logic [2:0] idx);
    rgb565_t c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_color_bar.sv
// Eight-bar colour test pattern. The enable is captured once per frame so a
// frame is never half pattern, half picture, and the bar colour is registered
// so it lines up with the one-cycle picture-generator latency.
// Only instantiated when VGA_TEST_PATTERN_EN is defined.
module vga_color_bar
  import vga_pkg::*;
#(
  parameter int BAR_W = 80
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       frame_start,
  input  logic       test_en,
  input  logic       pix_data_req,
  input  logic [9:0] pix_x,
  output logic       pat_en,
  output rgb565_t    pat_data
);

  logic [9:0] bar_idx;
  logic [2:0] bar_sel;

  // Which bar the requested column falls in; anything past the eighth is black
  always_comb begin
    bar_idx = pix_x / 10'(BAR_W);
    bar_sel = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
  end

  // Hold the pattern enable for a whole frame, sampled at the frame origin
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      pat_en <= 1'b0;
    else if (frame_start)
      pat_en <= test_en;
  end

  // Register the bar colour so it arrives together with the returned pixel
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      pat_data <= BLACK;
    else
      pat_data <= pix_data_req ? bar_color(bar_sel) : BLACK;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator and pixel-output stage. Two free-running counters are
// the only state; sync, request coordinates and RGB gating decode from them.
// Pixel requests lead the visible window by one clock to cover the picture
// generator's registered output.
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_en port and an
// internal colour-bar pattern (vga_color_bar).
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_VALID = H_VALID_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_VALID = V_VALID_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_data_req,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [9:0] H_MAX       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] H_REQ_START = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_END   = 10'(H_SYNC + H_BACK + H_VALID - 2);
  localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BACK + V_VALID - 1);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_visible;
  logic       h_request;
  logic       v_visible;
  logic       visible;
  rgb565_t    pixel_src;

  // Column counter: runs every clock, wraps at the end of the line
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      cnt_h <= 10'd0;
    else if (cnt_h == H_MAX)
      cnt_h <= 10'd0;
    else
      cnt_h <= cnt_h + 10'd1;
  end

  // Line counter: advances on the last column, wraps at the end of the frame
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      cnt_v <= 10'd0;
    else if (cnt_h == H_MAX) begin
      if (cnt_v == V_MAX)
        cnt_v <= 10'd0;
      else
        cnt_v <= cnt_v + 10'd1;
    end
  end

  // Window decode; the request window is the visible window one column early
  always_comb begin
    h_visible = (cnt_h >= H_VIS_START) && (cnt_h <= H_VIS_END);
    h_request = (cnt_h >= H_REQ_START) && (cnt_h <= H_REQ_END);
    v_visible = (cnt_v >= V_VIS_START) && (cnt_v <= V_VIS_END);
    visible   = h_visible && v_visible;
  end

  // Sync pulses, frame marker and request coordinates
  always_comb begin
    hsync        = (cnt_h < 10'(H_SYNC));
    vsync        = (cnt_v < 10'(V_SYNC));
    frame_start  = (cnt_h == 10'd0) && (cnt_v == 10'd0);
    pix_data_req = h_request && v_visible;
    pix_x        = pix_data_req ? (cnt_h - H_REQ_START) : COORD_INVALID;
    pix_y        = pix_data_req ? (cnt_v - V_VIS_START) : COORD_INVALID;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic    pat_en;
  rgb565_t pat_data;

  vga_color_bar #(
    .BAR_W (H_VALID / 8)
  ) u_color_bar (
    .vga_clk      (vga_clk),
    .sys_rst_n    (sys_rst_n),
    .frame_start  (frame_start),
    .test_en      (test_en),
    .pix_data_req (pix_data_req),
    .pix_x        (pix_x),
    .pat_en       (pat_en),
    .pat_data     (pat_data)
  );

  // Pattern replaces the picture generator's data for the whole frame
  always_comb begin
    pixel_src = pat_en ? pat_data : pix_data;
  end
`else
  // Picture generator data passes straight through
  always_comb begin
    pixel_src = pix_data;
  end
`endif

  // Blank the pins outside the visible window
  always_comb begin
    rgb = visible ? pixel_src : BLACK;
  end

endmodule
